seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: W, default 8, datapath width in bits (legal range 4..32).
REQ-002 Parameter: MUL_EN, default 1; when 1, MUL is multi-cycle shift-add; when 0, MUL is treated as an illegal op.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 alu_cmd  input  3  opcode: 000 PASSA, 001 SUB, 010 ABSJ, 011 XOR, 100 ROTL, 101 AND, 110 MUL, 111 ADD.
REQ-008 inA, inB  input  W  operands.
REQ-009 sc_i  input  1  carry/borrow in, used by ADD and SUB only.
REQ-010 out_valid  output  1  registered result present.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 rslt  output  W  result.
REQ-013 sc_o  output  1  carry/borrow/overflow out.
REQ-014 zero, pari, absj  output  1 each  result==0; XOR-reduction of rslt; inA!=0 (ABSJ only, else 0).
REQ-015 busy  output  1  high while a multi-cycle MUL is in progress.

Function
REQ-016 States: IDLE, MUL, HOLD; every operand and opcode is captured only on accept (in_valid && in_ready).
REQ-017 in_ready = (state==IDLE) && (!out_valid || out_ready); in_ready is low in MUL and while an unconsumed result is held.
REQ-018 Single-cycle ops: accept at edge N -> out_valid=1 with result from edge N (one-cycle latency); back-to-back accepts sustain one op per cycle when out_ready=1.
REQ-019 ADD: {sc_o,rslt} = inA + inB + sc_i, full W+1-bit sum.
REQ-020 SUB: rslt = inA - inB - sc_i modulo 2^W; sc_o = 1 on borrow (inA < inB + sc_i).
REQ-021 XOR, AND, PASSA: bitwise on W bits; sc_o = 0.
REQ-022 ROTL: left rotate of inA by (inB mod W); amount 0 returns inA unchanged; sc_o = 0.
REQ-023 ABSJ: rslt = 0, absj = (inA != 0), sc_o = 0.
REQ-024 MUL: IDLE->MUL on accept; W iterations of shift-add, one per cycle; MUL->HOLD after iteration W; rslt = low W bits of product, sc_o = OR of high W bits; busy=1 exactly W cycles.
REQ-025 zero and pari are always derived from the registered rslt of the held result, never from a default value.
REQ-026 HOLD / any out_valid=1 with out_ready=0: rslt, sc_o, zero, pari, absj remain stable until consumed.
REQ-027 Output consumed (out_valid && out_ready) with no new accept: out_valid falls next edge, outputs keep last values.
REQ-028 Simultaneous consume and accept: new result replaces old at the same edge, out_valid stays 1.
REQ-029 MUL with MUL_EN=0: completes in one cycle with rslt=0, sc_o=1.
REQ-030 in_valid while in_ready=0: request ignored, no state change; requester must hold it.

Reset
REQ-031 rst_n low: immediately state=IDLE, out_valid=0, busy=0, rslt=0, sc_o=0, absj=0, zero=1, pari=0, MUL iteration counter=0.
REQ-032 Reset asserted mid-MUL aborts the operation; no result is produced after release.
REQ-033 First accept is possible on the first rising edge after rst_n deasserts.

Verification (W=8)
REQ-034 ADD inA=0xFF, inB=0x01, sc_i=0 -> next cycle rslt=0x00, sc_o=1, zero=1, pari=0.
REQ-035 SUB inA=0x05, inB=0x07, sc_i=0 -> rslt=0xFE, sc_o=1; ROTL inA=0x81, inB=9 -> rslt=0x03.
REQ-036 MUL inA=0x10, inB=0x20 -> busy 8 cycles, in_ready=0 throughout, then rslt=0x00, sc_o=1, zero=1.
REQ-037 XOR 0x0F^0x01 with out_ready=0 for 5 cycles -> rslt=0x0E, pari=1 held stable, in_ready=0 until consume.
REQ-038 Stream 4 ADDs with out_ready=1 -> 4 results on 4 consecutive cycles; assert rst_n low at MUL cycle 3 -> out_valid=0, busy=0 immediately, no stale result after release.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with one-cycle ops and a W-cycle shift-add multiplier
module seq_alu #(
    parameter int W      = 8,
    parameter int MUL_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   alu_cmd,
    input  logic [W-1:0] inA,
    input  logic [W-1:0] inB,
    input  logic         sc_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] rslt,
    output logic         sc_o,
    output logic         zero,
    output logic         pari,
    output logic         absj,
    output logic         busy
);
    localparam int            CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    localparam logic [W-1:0]  WV   = W'(W);

    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] prod, prod_nxt;
    logic [W-1:0]   mcand, amt, res;
    logic [W:0]     hsum, sum, diff;
    logic           car, aj, accept, is_mul, last;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (MUL_EN != 0) && (alu_cmd == 3'b110);
    assign busy     = state == MUL;
    assign last     = cnt == LAST;
    assign zero     = rslt == '0;
    assign pari     = ^rslt;
    assign sum      = {1'b0, inA} + {1'b0, inB} + {{W{1'b0}}, sc_i};
    assign diff     = {1'b0, inA} - {1'b0, inB} - {{W{1'b0}}, sc_i};
    assign amt      = inB % WV;
    // product register: high half accumulates, low half shifts out the multiplier
    assign hsum     = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : '0);
    assign prod_nxt = {hsum, prod[W-1:1]};

    always_comb begin
        res = '0;
        car = 1'b0;
        aj  = 1'b0;
        case (alu_cmd)
            3'b000:  res = inA;
            3'b001:  {car, res} = diff;
            3'b010:  aj = inA != '0;
            3'b011:  res = inA ^ inB;
            3'b100:  res = (inA << amt) | (inA >> (WV - amt));
            3'b101:  res = inA & inB;
            3'b110:  car = 1'b1;
            default: {car, res} = sum;
        endcase
    end

    always_comb begin
        state_nxt = (accept && is_mul)           ? MUL
                  : (state == MUL && last)       ? HOLD
                  : (state == HOLD && out_ready) ? IDLE
                  : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            rslt      <= '0;
            sc_o      <= 1'b0;
            absj      <= 1'b0;
            cnt       <= '0;
            prod      <= '0;
            mcand     <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept && is_mul) begin
                prod  <= {{W{1'b0}}, inB};
                mcand <= inA;
            end else if (accept) begin
                rslt      <= res;
                sc_o      <= car;
                absj      <= aj;
                out_valid <= 1'b1;
            end
            if (busy) begin
                prod <= prod_nxt;
                cnt  <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    rslt      <= prod_nxt[W-1:0];
                    sc_o      <= |prod_nxt[2*W-1:W];
                    absj      <= 1'b0;
                    out_valid <= 1'b1;
                end
            end
        end
    end
endmodule
